// File: rtl/wb_port_decoder_pkg.sv
// Shared types and constants for the register-file write-enable decoder.
// The block and its interface import this package with: import wb_dec_pkg::*;
package wb_dec_pkg;

  // Default register address width (16 architectural registers).
  localparam int ADDR_W_DEF = 4;

  // Width of the deferred-write (conflict) event counter.
  localparam int CNT_W = 16;

  // PASS: port B is accepted directly.
  // HOLD: a deferred B write waits in the hold buffer.
  typedef enum logic [0:0] {
    PASS = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage : wb_dec_pkg

// File: rtl/wb_port_decoder_if.sv
// Bus bundle between the writeback stage (master) and the decoder (slave).
//
// Handshake semantics:
//   Port A has no handshake. It is sampled on every rising edge where en=1
//   and never stalls.
//   Port B uses valid/ready. A transfer happens on a rising edge where
//   b_valid & b_ready. The master must hold b_valid and b_addr stable
//   until that edge. b_ready may drop without a pending request and does
//   not depend on b_valid.
interface wb_port_decoder_if
  import wb_dec_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  localparam int NUM_OUT = 1 << ADDR_W;

  logic              en;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic              b_ready;
  logic [NUM_OUT-1:0] sel_a;
  logic [NUM_OUT-1:0] sel_b;
  logic              we_any;
  logic              conflict;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output en, a_valid, a_addr, b_valid, b_addr,
    input  b_ready, sel_a, sel_b, we_any, conflict, conflict_cnt
  );

  modport slave (
    input  en, a_valid, a_addr, b_valid, b_addr,
    output b_ready, sel_a, sel_b, we_any, conflict, conflict_cnt
  );

endinterface : wb_port_decoder_if

// File: rtl/wb_port_decoder_onehot_dec.sv
// Combinational address to one-hot decoder with an enable.
// When disabled, the output is all zeros.
module onehot_dec #(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     enable,
  output logic [(1 << ADDR_W)-1:0] onehot
);

  // Set the single bit selected by addr when enabled.
  always_comb begin
    onehot = '0;
    if (enable) onehot[addr] = 1'b1;
  end

endmodule : onehot_dec

// File: rtl/wb_port_decoder.sv
// Registered write-enable decoder for two register-file write ports.
// Port A (ALU result) always wins. If port B (load writeback) targets the
// same register on the same cycle, B is deferred through a one-entry hold
// buffer and b_ready is dropped until the held write has issued.
//
// Optional feature, macro WB_PORT_DECODER_CONFLICT_CNT_EN:
//   Defined:   conflict_cnt is a saturating count of deferral cycles.
//   Undefined: conflict_cnt is tied to zero and no counter flops exist.
module wb_port_decoder
  import wb_dec_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_port_decoder_if.slave   bus,
  output state_t             state_dbg
);

  localparam int NUM_OUT = 1 << ADDR_W;

  state_t             state_q;
  state_t             state_d;
  logic [ADDR_W-1:0]  hold_addr_q;
  logic [ADDR_W-1:0]  hold_addr_d;
  logic [NUM_OUT-1:0] sel_a_q;
  logic [NUM_OUT-1:0] sel_b_q;
  logic [NUM_OUT-1:0] sel_a_d;
  logic [NUM_OUT-1:0] sel_b_d;
  logic               we_any_q;
  logic               we_any_d;
  logic               conflict_q;
  logic               conflict_d;

  logic [NUM_OUT-1:0] oh_a;
  logic [NUM_OUT-1:0] oh_b;
  logic [ADDR_W-1:0]  b_path_addr;
  logic               b_ready;
  logic               b_xfer;
  logic               collide;

  // B is offered only in PASS with decode enabled. Gating with reset_n
  // ensures the master never sees a transfer that would be discarded.
  assign b_ready = bus.en & reset_n & (state_q == PASS);
  assign b_xfer  = bus.b_valid & b_ready;

  // The B decoder serves the live request in PASS and the held one in HOLD.
  assign b_path_addr = (state_q == HOLD) ? hold_addr_q : bus.b_addr;

  // A collision means port A targets the register that B wants this cycle.
  assign collide = bus.a_valid & (bus.a_addr == b_path_addr);

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec_a (
    .addr   (bus.a_addr),
    .enable (bus.en & bus.a_valid),
    .onehot (oh_a)
  );

  onehot_dec #(.ADDR_W(ADDR_W)) u_dec_b (
    .addr   (b_path_addr),
    .enable (1'b1),
    .onehot (oh_b)
  );

  // Next-state and next-output decode. Port A always issues; B issues
  // only when it does not collide with A.
  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    sel_a_d     = oh_a;
    sel_b_d     = '0;
    conflict_d  = 1'b0;
    if (bus.en) begin
      case (state_q)
        PASS: begin
          if (b_xfer) begin
            if (collide) begin
              hold_addr_d = bus.b_addr;
              conflict_d  = 1'b1;
              state_d     = HOLD;
            end else begin
              sel_b_d = oh_b;
            end
          end
        end
        HOLD: begin
          if (collide) begin
            conflict_d = 1'b1;
          end else begin
            sel_b_d = oh_b;
            state_d = PASS;
          end
        end
        default: state_d = PASS;
      endcase
    end
    we_any_d = (|sel_a_d) | (|sel_b_d);
  end

  // FSM and registered outputs. Reset drops any held B write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= PASS;
      hold_addr_q <= '0;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      we_any_q    <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      we_any_q    <= we_any_d;
      conflict_q  <= conflict_d;
    end
  end

`ifdef WB_PORT_DECODER_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count deferral cycles. The count saturates at all-ones and is
  // cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (conflict_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.conflict_cnt = cnt_q;
`else
  assign bus.conflict_cnt = '0;
`endif

  assign bus.b_ready  = b_ready;
  assign bus.sel_a    = sel_a_q;
  assign bus.sel_b    = sel_b_q;
  assign bus.we_any   = we_any_q;
  assign bus.conflict = conflict_q;
  assign state_dbg    = state_q;

endmodule : wb_port_decoder

// File: tb/tb_wb_port_decoder.sv
// Directed bench for wb_port_decoder: a 4-bit address instance and a
// 5-bit address instance, driven from one linear initial block.
module tb_wb_port_decoder;
  import wb_dec_pkg::*;

`ifdef WB_PORT_DECODER_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  wb_port_decoder_if #(.ADDR_W(4)) bus4 ();
  wb_port_decoder_if #(.ADDR_W(5)) bus5 ();
  state_t st4;
  state_t st5;

  wb_port_decoder #(.ADDR_W(4)) u_dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus4),
    .state_dbg (st4)
  );

  wb_port_decoder #(.ADDR_W(5)) u_dut5 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus5),
    .state_dbg (st5)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic en, input logic av, input logic [3:0] aa,
                        input logic bv, input logic [3:0] ba);
    bus4.en = en; bus4.a_valid = av; bus4.a_addr = aa;
    bus4.b_valid = bv; bus4.b_addr = ba;
  endtask

  task automatic drive5(input logic en, input logic av, input logic [4:0] aa,
                        input logic bv, input logic [4:0] ba);
    bus5.en = en; bus5.a_valid = av; bus5.a_addr = aa;
    bus5.b_valid = bv; bus5.b_addr = ba;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    // 1. reset with every input active
    reset_n = 1'b0;
    drive4(1'b1, 1'b1, 4'd3, 1'b1, 4'd9);
    drive5(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    step();
    check("rst_sel_a", 32'(bus4.sel_a), 32'h0);
    check("rst_sel_b", 32'(bus4.sel_b), 32'h0);
    check("rst_we_any", 32'(bus4.we_any), 32'h0);
    check("rst_conflict", 32'(bus4.conflict), 32'h0);
    check("rst_cnt", 32'(bus4.conflict_cnt), 32'h0);
    check("rst_b_ready", 32'(bus4.b_ready), 32'h0);
    reset_n = 1'b1;
    #1;
    check("rel_b_ready", 32'(bus4.b_ready), 32'h1);

    // 2. independent A=3, B=9
    step();
    check("t2_sel_a", 32'(bus4.sel_a), 32'h0008);
    check("t2_sel_b", 32'(bus4.sel_b), 32'h0200);
    check("t2_we_any", 32'(bus4.we_any), 32'h1);
    check("t2_conflict", 32'(bus4.conflict), 32'h0);

    // 3. collision on register 5, then release
    drive4(1'b1, 1'b1, 4'd5, 1'b1, 4'd5);
    step();
    check("t3_sel_a", 32'(bus4.sel_a), 32'h0020);
    check("t3_sel_b", 32'(bus4.sel_b), 32'h0);
    check("t3_conflict", 32'(bus4.conflict), 32'h1);
    check("t3_b_ready", 32'(bus4.b_ready), 32'h0);
    check("t3_state", 32'(st4), 32'(HOLD));
    drive4(1'b1, 1'b0, 4'd5, 1'b0, 4'd0);
    step();
    check("t3r_sel_a", 32'(bus4.sel_a), 32'h0);
    check("t3r_sel_b", 32'(bus4.sel_b), 32'h0020);
    check("t3r_conflict", 32'(bus4.conflict), 32'h0);
    check("t3r_we_any", 32'(bus4.we_any), 32'h1);
    check("t3r_b_ready", 32'(bus4.b_ready), 32'h1);
    check("t3r_state", 32'(st4), 32'(PASS));
    check("t3r_cnt", 32'(bus4.conflict_cnt), exp_cnt(1));

    // 4. repeated collision from a fresh reset
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("t4_cnt_clr", 32'(bus4.conflict_cnt), 32'h0);
    drive4(1'b1, 1'b1, 4'd5, 1'b1, 4'd5);
    step();
    check("t4_first_conflict", 32'(bus4.conflict), 32'h1);
    // B inputs are ignored while holding; present a different address
    drive4(1'b1, 1'b1, 4'd5, 1'b1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_rep_conflict", 32'(bus4.conflict), 32'h1);
      check("t4_rep_sel_b", 32'(bus4.sel_b), 32'h0);
      check("t4_rep_sel_a", 32'(bus4.sel_a), 32'h0020);
    end
    drive4(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    check("t4_issue_sel_b", 32'(bus4.sel_b), 32'h0020);
    check("t4_issue_conflict", 32'(bus4.conflict), 32'h0);
    check("t4_cnt", 32'(bus4.conflict_cnt), exp_cnt(4));

    // 5a. en=0 while holding register 7
    drive4(1'b1, 1'b1, 4'd7, 1'b1, 4'd7);
    step();
    check("t5_hold_conflict", 32'(bus4.conflict), 32'h1);
    drive4(1'b0, 1'b1, 4'd2, 1'b1, 4'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t5_dis_sel_a", 32'(bus4.sel_a), 32'h0);
      check("t5_dis_sel_b", 32'(bus4.sel_b), 32'h0);
      check("t5_dis_we_any", 32'(bus4.we_any), 32'h0);
      check("t5_dis_conflict", 32'(bus4.conflict), 32'h0);
      check("t5_dis_b_ready", 32'(bus4.b_ready), 32'h0);
      check("t5_dis_state", 32'(st4), 32'(HOLD));
    end
    drive4(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    check("t5_en_sel_b", 32'(bus4.sel_b), 32'h0080);
    check("t5_en_state", 32'(st4), 32'(PASS));
    check("t5_cnt", 32'(bus4.conflict_cnt), exp_cnt(5));

    // 5b. reset while holding register 12 discards the write
    drive4(1'b1, 1'b1, 4'd12, 1'b1, 4'd12);
    step();
    check("t5b_hold_state", 32'(st4), 32'(HOLD));
    drive4(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    reset_n = 1'b0;
    step();
    check("t5b_rst_sel_b", 32'(bus4.sel_b), 32'h0);
    reset_n = 1'b1;
    step();
    check("t5b_after_sel_b", 32'(bus4.sel_b), 32'h0);
    check("t5b_after_state", 32'(st4), 32'(PASS));
    check("t5b_after_cnt", 32'(bus4.conflict_cnt), 32'h0);

    // 6. five-bit build: top register, then a sweep of both ports
    drive4(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    drive5(1'b1, 1'b1, 5'd31, 1'b0, 5'd0);
    step();
    check("t6_sel_a31", bus5.sel_a, 32'h8000_0000);
    check("t6_sel_b31", bus5.sel_b, 32'h0);
    check("t6_we_any31", 32'(bus5.we_any), 32'h1);
    for (int i = 0; i < 32; i++) begin
      drive5(1'b1, 1'b1, 5'(i), 1'b1, 5'((i + 1) % 32));
      step();
      exp_a = 32'h1 << i;
      exp_b = 32'h1 << ((i + 1) % 32);
      check("t6_sweep_sel_a", bus5.sel_a, exp_a);
      check("t6_sweep_sel_b", bus5.sel_b, exp_b);
      check("t6_sweep_overlap", bus5.sel_a & bus5.sel_b, 32'h0);
    end
    check("t6_state", 32'(st5), 32'(PASS));
    check("t6_conflict", 32'(bus5.conflict), 32'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_port_decoder

// File: doc/wb_port_decoder.md
Name: wb_port_decoder

Overview:
- Parametrised, registered register-file write-enable decoder for the ARM datapath.
- Two write ports: A (ALU result) and B (load writeback). Each turns an ADDR_W-bit register address into a one-hot write-enable vector.
- Same-register collisions are resolved by giving A priority and deferring B through a single-entry hold buffer with a ready handshake.
- Sits between the writeback stage and the register file.

Parameters:
- ADDR_W, 4: register address width.
- NUM_OUT, 2**ADDR_W: one-hot vector width. Derived localparam; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  global decode enable.
- a_valid  in  1  port A write request.
- a_addr  in  ADDR_W  port A destination register.
- b_valid  in  1  port B write request.
- b_addr  in  ADDR_W  port B destination register.
- b_ready  out  1  port B may present a request (combinational).
- sel_a  out  NUM_OUT  registered one-hot write enable, port A.
- sel_b  out  NUM_OUT  registered one-hot write enable, port B.
- we_any  out  1  registered; OR of all bits of sel_a and sel_b.
- conflict  out  1  registered one-cycle pulse: a B write was deferred.
- conflict_cnt  out  16  conflict counter (see Optional Feature).

Behaviour:
- Interface fixed: one clock `clk`; reset `reset_n`, synchronous, active-low (sampled only on the rising edge of clk).
- Reset:
  - sel_a=0, sel_b=0, we_any=0, conflict=0, conflict_cnt=0.
  - State = PASS; hold_addr=0.
  - A held B write is discarded on reset.
- Latency: a request sampled at edge N appears on sel_* after edge N (one cycle). No combinational path from inputs to sel_*.
- b_ready = en & (state==PASS). A B transfer occurs on an edge where b_valid & b_ready.
- Port A has no handshake, never stalls, and always has priority.
- Port A decode: sel_a <= (en & a_valid) ? onehot(a_addr) : 0.
- State PASS, en=1:
  - B transfer with no collision (~a_valid, or a_addr != b_addr): sel_b <= onehot(b_addr); stay PASS.
  - B transfer with collision (a_valid & a_addr==b_addr): hold_addr <= b_addr; sel_b <= 0; conflict <= 1; go to HOLD.
  - No B transfer: sel_b <= 0.
- State HOLD, en=1 (b_ready=0, b_valid/b_addr ignored):
  - No collision with hold_addr: sel_b <= onehot(hold_addr); go to PASS.
  - a_valid & a_addr==hold_addr: sel_b <= 0; conflict <= 1; stay HOLD.
- en=0, either state:
  - sel_a, sel_b, conflict <= 0.
  - State and hold_addr retained.
  - Port A requests are dropped. B is not accepted because b_ready=0.
- conflict is 0 on every cycle except a deferral cycle.
- we_any is computed from the next-state sel values, so it is aligned with sel_*.
- A continuous A stream to the held register starves B indefinitely. This is by design: the pipeline guarantees it cannot happen.
- All address values are legal. Addresses wrap within ADDR_W; there are no out-of-range cases.
- sel_a and sel_b are never both nonzero at the same bit position.

Optional Feature:
- Macro: WB_PORT_DECODER_CONFLICT_CNT_EN.
- Defined:
  - conflict_cnt is a 16-bit counter that increments on every cycle where conflict is registered to 1.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: conflict_cnt is tied to 16'h0000 and no counter flops are inferred.

Decomposition:
- Package wb_dec_pkg:
  - ADDR_W default constant.
  - State enum {PASS, HOLD}.
  - Counter width constant CNT_W=16.
- Sub-module onehot_dec:
  - Combinational, parametrised ADDR_W, inputs addr and enable, one-hot output.
  - Instantiated for port A and for the B/hold path; the B/hold input is muxed between b_addr and hold_addr.

Test Plan:
1. Reset with reset_n=0 for 2 cycles, all inputs active -> every output 0; b_ready=0 during reset, b_ready=1 on the first cycle after release with en=1.
2. en=1, a_valid=1 a_addr=3, b_valid=1 b_addr=9 -> next cycle sel_a=16'h0008, sel_b=16'h0200, we_any=1, conflict=0.
3. Collision:
   - Stimulus: a_addr=b_addr=5, both valid.
   - Next cycle: sel_a=16'h0020, sel_b=0, conflict=1, b_ready=0.
   - Following cycle with a_valid=0: sel_b=16'h0020, state returns to PASS, b_ready=1.
4. Repeated collision: A writes 5 for 3 cycles while B is held at 5 -> conflict high 3 cycles, sel_b=0 throughout, then sel_b=16'h0020; with the macro defined, conflict_cnt=4 (initial deferral plus 3).
5. en=0 while in HOLD for 2 cycles -> sel_*=0, b_ready=0; after en=1, the held write issues on sel_b. Separately, reset asserted in HOLD -> the held write never appears.
6. ADDR_W=5 build, a_addr=31 -> sel_a bit 31 only, NUM_OUT=32; sweep all addresses on both ports and check sel_* is one-hot each time.
